// File: rtl/uart_tx_arbiter_if.sv
// Requester / uart_tx byte handshake bundle for uart_tx_arbiter.
// master = requesters plus transmitter side, slave = the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_vld;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [7:0]           tx_din;
    logic                 tx_din_vld;
    logic                 tx_din_rdy;
    logic                 busy;
    logic [ID_WIDTH-1:0]  grant_id;

    modport master (
        output req_data, req_vld, req_last, tx_din_rdy,
        input  req_rdy, tx_din, tx_din_vld, busy, grant_id
    );

    modport slave (
        input  req_data, req_vld, req_last, tx_din_rdy,
        output req_rdy, tx_din, tx_din_vld, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional idle-grant timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rstz,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t              state_q;
    logic [ID_WIDTH-1:0] grant_q;
    logic [7:0]          din_q;
    logic                vld_q;
    logic                busy_q;
    logic                last_q;

    logic [7:0]          sel_data;
    logic                sel_vld;
    logic                sel_last;
    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_id;
    logic [ID_WIDTH-1:0] cand;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_WIDTH-1:0] cnt_q;
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
    end

    // Granted requester's byte lane
    always_comb begin
        sel_data = 8'h00;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_data = bus.req_data[i*8 +: 8];
                sel_vld  = bus.req_vld[i];
                sel_last = bus.req_last[i];
            end
        end
    end

    // First valid requester after the rotation pointer, wrapping modulo NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_id    = grant_q;
        cand       = grant_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_WIDTH'((32'(grant_q) + k) % NUM_REQ);
            if (!pick_found && bus.req_vld[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign bus.req_rdy    = (state_q == FETCH && sel_vld) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.tx_din     = din_q;
    assign bus.tx_din_vld = vld_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            grant_q <= ID_WIDTH'(NUM_REQ - 1);
            din_q   <= 8'h00;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_id;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (sel_vld) begin
                        din_q   <= sel_data;
                        last_q  <= sel_last;
                        vld_q   <= 1'b1;
                        state_q <= SEND;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    // A stalled requester loses its grant as if its packet had ended
                    else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                    end
`endif
                end
                SEND: begin
                    if (bus.tx_din_rdy) begin
                        vld_q <= 1'b0;
                        if (last_q) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= FETCH;
`ifdef UART_ARB_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// scored against a packet-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 3;
    localparam int unsigned IDW = 2;
    localparam int unsigned TO  = 16;

    logic clk = 1'b0;
    logic rstz;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .ID_WIDTH(IDW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-requester source queues: {last, data}
    logic [8:0]  srcq [NR][$];
    // Expected delivery stream: {id, last, data}
    logic [10:0] expq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sources();
        logic [NR*8-1:0] d;
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        d = '0; v = '0; l = '0;
        for (int i = 0; i < NR; i++) begin
            if (srcq[i].size() > 0) begin
                v[i]        = 1'b1;
                d[i*8 +: 8] = srcq[i][0][7:0];
                l[i]        = srcq[i][0][8];
            end
        end
        bus.req_data = d;
        bus.req_vld  = v;
        bus.req_last = l;
    endtask

    task automatic clear_inputs();
        bus.req_data   = '0;
        bus.req_vld    = '0;
        bus.req_last   = '0;
        bus.tx_din_rdy = 1'b0;
        for (int i = 0; i < NR; i++) srcq[i].delete();
    endtask

    task automatic do_reset();
        rstz = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstz = 1'b1;
        tick();
    endtask

    task automatic push_packet(input int id, input int len);
        for (int j = 0; j < len; j++)
            srcq[id].push_back({(j == len - 1), 8'($urandom_range(0, 255))});
    endtask

    // Packet-level round robin: winner is the first non-empty source after the pointer
    task automatic build_expected();
        logic [8:0] mq [NR][$];
        logic [8:0] e;
        int unsigned ptr;
        int found;
        for (int i = 0; i < NR; i++) mq[i] = srcq[i];
        ptr = NR - 1;
        expq.delete();
        while (1) begin
            found = -1;
            for (int unsigned k = 1; k <= NR; k++)
                if (found < 0 && mq[(ptr + k) % NR].size() > 0) found = int'((ptr + k) % NR);
            if (found < 0) break;
            do begin
                e = mq[found].pop_front();
                expq.push_back({IDW'(found), e});
            end while (!e[8] && mq[found].size() > 0);
            ptr = found;
        end
    endtask

    task automatic run_traffic(input int budget, input int rdy_pct);
        int         cyc;
        logic [NR-1:0] acc;
        logic       pv, pr;
        logic [7:0] pd;
        cyc = 0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
        build_expected();
        drive_sources();
        bus.tx_din_rdy = 1'b0;
        while (expq.size() > 0 && cyc < budget) begin
            @(negedge clk);
            acc = bus.req_rdy;
            total++;
            if (acc !== (acc & bus.req_vld) || !$onehot0(acc)) begin
                bad++;
                $display("FAIL rdy_onehot got=%b vld=%b", acc, bus.req_vld);
            end
            if (acc != '0) begin
                total++;
                if (acc !== (NR'(1) << expq[0][10:9])) begin
                    bad++;
                    $display("FAIL rdy_id got=%b exp_id=%0d", acc, expq[0][10:9]);
                end
            end
            if (pv && !pr) begin
                total++;
                if (bus.tx_din_vld !== 1'b1 || bus.tx_din !== pd) begin
                    bad++;
                    $display("FAIL stable got=%b/%h exp=1/%h", bus.tx_din_vld, bus.tx_din, pd);
                end
            end
            if (bus.tx_din_vld && bus.tx_din_rdy) begin
                total++;
                if ({bus.grant_id, bus.tx_din} !== {expq[0][10:9], expq[0][7:0]}) begin
                    bad++;
                    $display("FAIL byte got=%0d/%h exp=%0d/%h", bus.grant_id, bus.tx_din,
                             expq[0][10:9], expq[0][7:0]);
                end
                void'(expq.pop_front());
            end
            pv = bus.tx_din_vld; pd = bus.tx_din; pr = bus.tx_din_rdy;
            tick();
            for (int i = 0; i < NR; i++) if (acc[i]) void'(srcq[i].pop_front());
            drive_sources();
            if (bus.tx_din_vld) bus.tx_din_rdy = ($urandom_range(0, 99) < rdy_pct);
            else                bus.tx_din_rdy = ($urandom_range(0, 9) == 0);
            cyc++;
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL traffic_timeout got=%0d pending exp=0", expq.size());
        end
        bus.tx_din_rdy = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.tx_din_vld !== 1'b0) begin
            bad++;
            $display("FAIL traffic_end got busy=%b vld=%b exp=0/0", bus.busy, bus.tx_din_vld);
        end
    endtask

    task automatic test_reset();
        rstz = 1'b0;
        clear_inputs();
        bus.req_vld = 3'b111;
        @(negedge clk);
        total++;
        if ({bus.tx_din_vld, bus.tx_din, bus.req_rdy, bus.busy, bus.grant_id} !==
            {1'b0, 8'h00, 3'b000, 1'b0, 2'd2}) begin
            bad++;
            $display("FAIL reset got vld=%b din=%h rdy=%b busy=%b gid=%0d exp=0/00/000/0/2",
                     bus.tx_din_vld, bus.tx_din, bus.req_rdy, bus.busy, bus.grant_id);
        end
        do_reset();
    endtask

    task automatic test_single_byte();
        do_reset();
        bus.req_data = {8'h00, 8'h00, 8'h41};
        bus.req_last = 3'b001;
        bus.req_vld  = 3'b001;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.req_rdy !== 3'b000) begin
            bad++;
            $display("FAIL single_idle got busy=%b rdy=%b exp=0/000", bus.busy, bus.req_rdy);
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus.grant_id, bus.busy, bus.req_rdy, bus.tx_din_vld} !== {2'd0, 1'b1, 3'b001, 1'b0}) begin
            bad++;
            $display("FAIL single_fetch got gid=%0d busy=%b rdy=%b vld=%b exp=0/1/001/0",
                     bus.grant_id, bus.busy, bus.req_rdy, bus.tx_din_vld);
        end
        tick();
        bus.req_vld = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (bus.tx_din_vld !== 1'b1 || bus.tx_din !== 8'h41 || bus.req_rdy !== 3'b000) begin
                bad++;
                $display("FAIL single_hold got vld=%b din=%h rdy=%b exp=1/41/000",
                         bus.tx_din_vld, bus.tx_din, bus.req_rdy);
            end
            tick();
        end
        bus.tx_din_rdy = 1'b1;
        tick();
        bus.tx_din_rdy = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.tx_din_vld, bus.busy, bus.grant_id} !== {1'b0, 1'b0, 2'd0}) begin
            bad++;
            $display("FAIL single_done got vld=%b busy=%b gid=%0d exp=0/0/0",
                     bus.tx_din_vld, bus.busy, bus.grant_id);
        end
    endtask

    task automatic test_two_packets();
        do_reset();
        srcq[0].push_back({1'b0, 8'h41}); srcq[0].push_back({1'b0, 8'h42}); srcq[0].push_back({1'b1, 8'h43});
        srcq[1].push_back({1'b0, 8'h78}); srcq[1].push_back({1'b0, 8'h79}); srcq[1].push_back({1'b1, 8'h7A});
        run_traffic(500, 50);
    endtask

    task automatic test_fairness();
        do_reset();
        push_packet(0, 1); push_packet(0, 1);
        for (int p = 0; p < 3; p++) push_packet(1, 1);
        run_traffic(500, 60);
    endtask

    task automatic test_wrap();
        do_reset();
        push_packet(2, 2); push_packet(2, 1);
        run_traffic(500, 60);
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.req_data = {8'h00, 8'h55, 8'h00};
        bus.req_last = 3'b000;
        bus.req_vld  = 3'b010;
        tick();
        tick();
        bus.req_vld = 3'b000;
        @(negedge clk);
        #2;
        rstz = 1'b0;
        #1;
        total++;
        if ({bus.tx_din_vld, bus.busy, bus.req_rdy, bus.grant_id, bus.tx_din} !==
            {1'b0, 1'b0, 3'b000, 2'd2, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid got vld=%b busy=%b rdy=%b gid=%0d din=%h exp=0/0/000/2/00",
                     bus.tx_din_vld, bus.busy, bus.req_rdy, bus.grant_id, bus.tx_din);
        end
        @(negedge clk);
        rstz = 1'b1;
        bus.req_data = {8'h00, 8'h55, 8'h11};
        bus.req_last = 3'b011;
        bus.req_vld  = 3'b011;
        tick();
        @(negedge clk);
        total++;
        if ({bus.grant_id, bus.req_rdy} !== {2'd0, 3'b001}) begin
            bad++;
            $display("FAIL reset_prio got gid=%0d rdy=%b exp=0/001", bus.grant_id, bus.req_rdy);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req_data = {8'h00, 8'h66, 8'h22};
        bus.req_last = 3'b001;
        bus.req_vld  = 3'b010;
        tick();
        tick();
        bus.tx_din_rdy = 1'b1;
        tick();
        bus.tx_din_rdy = 1'b0;
        bus.req_vld    = 3'b001;
`ifdef UART_ARB_TIMEOUT_EN
        for (int c = 0; c < TO - 1; c++) begin
            tick();
            @(negedge clk);
            total++;
            if ({bus.busy, bus.grant_id, bus.req_rdy} !== {1'b1, 2'd1, 3'b000}) begin
                bad++;
                $display("FAIL timeout_wait c=%0d got busy=%b gid=%0d rdy=%b exp=1/1/000",
                         c, bus.busy, bus.grant_id, bus.req_rdy);
            end
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.tx_din_vld !== 1'b0) begin
            bad++;
            $display("FAIL timeout_release got busy=%b vld=%b exp=0/0", bus.busy, bus.tx_din_vld);
        end
        tick();
        @(negedge clk);
        total++;
        if ({bus.grant_id, bus.req_rdy} !== {2'd0, 3'b001}) begin
            bad++;
            $display("FAIL timeout_regrant got gid=%0d rdy=%b exp=0/001", bus.grant_id, bus.req_rdy);
        end
`else
        for (int c = 0; c < 3 * TO; c++) begin
            tick();
            @(negedge clk);
            total++;
            if ({bus.busy, bus.grant_id, bus.req_rdy} !== {1'b1, 2'd1, 3'b000}) begin
                bad++;
                $display("FAIL no_timeout c=%0d got busy=%b gid=%0d rdy=%b exp=1/1/000",
                         c, bus.busy, bus.grant_id, bus.req_rdy);
            end
        end
`endif
        do_reset();
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) push_packet(i, $urandom_range(1, 4));
            end
            run_traffic(3000, $urandom_range(20, 90));
        end
    endtask

    initial begin
        rstz = 1'b0;
        clear_inputs();
        test_reset();
        test_single_byte();
        test_two_packets();
        test_fairness();
        test_wrap();
        test_reset_mid_packet();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter between NUM_REQ byte-stream requesters, for example the CPU debug console and a hardware trace dumper.
- Arbitration is round-robin at packet granularity. A grant is held until the requester's byte flagged "last" has been accepted by the transmitter, so packets never interleave on the serial line.
- Sits between the requesters and uart_tx's din/din_vld/din_rdy port.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ID_WIDTH, $clog2(NUM_REQ): width of the grant index.
- TIMEOUT_CYCLES, 1024: idle-grant timeout in cycles. Used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstz  in  1  reset, asynchronous, active-low.
- req_data  in  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i].
- req_vld  in  NUM_REQ  byte valid per requester.
- req_last  in  NUM_REQ  byte is the last of its packet.
- req_rdy  out  NUM_REQ  byte accepted, one-hot or zero.
- tx_din  out  8  byte to uart_tx.
- tx_din_vld  out  1  byte valid to uart_tx.
- tx_din_rdy  in  1  single-cycle pulse from uart_tx: byte taken.
- busy  out  1  a grant is held.
- grant_id  out  ID_WIDTH  current or last granted requester.

Behaviour:
- Reset (async, rstz=0):
  - state=IDLE; tx_din_vld=0; tx_din=8'h00; req_rdy=0; busy=0; grant_id=NUM_REQ-1.
  - The rotation pointer therefore gives requester 0 top priority first.
  - Reset mid-packet drops the held byte and the grant. No req_rdy pulse is issued for the dropped byte.
- States: IDLE, FETCH, SEND.
- IDLE:
  - If any req_vld bit is set, pick the first set bit scanning from grant_id+1 upward, wrapping modulo NUM_REQ.
  - Register the winner into grant_id and go to FETCH. This costs 1 cycle.
  - Otherwise stay in IDLE. busy=0 only in IDLE.
- FETCH:
  - req_rdy[grant_id] = req_vld[grant_id], combinationally; all other req_rdy bits are 0.
  - On acceptance, at the clock edge: load tx_din from req_data[grant_id], latch last_q from req_last[grant_id], set tx_din_vld=1, go to SEND.
  - req_vld from non-granted requesters is ignored; they wait.
- SEND:
  - Hold tx_din and tx_din_vld=1 stable until tx_din_rdy=1.
  - On tx_din_rdy: clear tx_din_vld at the next edge.
  - If last_q=1, go to IDLE; the rotation pointer is now grant_id, so the winner becomes lowest priority.
  - If last_q=0, go to FETCH.
  - Any tx_din_rdy pulse seen outside SEND is ignored.
- Latency: req_vld rising in IDLE gives req_rdy in the 2nd cycle and tx_din_vld in the 3rd cycle.
  - Back-to-back bytes: the next FETCH starts the cycle after tx_din_rdy.
  - uart_tx itself accepts only when its line is idle, so throughput is limited by the line.
- Stable-data rule: tx_din must not change while tx_din_vld=1.
- Simultaneous events:
  - Several req_vld bits in IDLE: the rotation decides.
  - Only one requester active: it is re-granted immediately after its packet.
  - req_vld and req_last both 1 on a single-byte packet is legal: 1-byte packet.
- Width: the rotation pointer wraps modulo NUM_REQ, also for non-power-of-2 NUM_REQ; grant_id never exceeds NUM_REQ-1.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to FETCH and increments every FETCH cycle with req_vld[grant_id]=0.
  - When it reaches TIMEOUT_CYCLES, the grant is released: go to IDLE, pointer updated as for an end of packet, no byte sent.
  - This guards against a requester stalling mid-packet.
- Undefined: the counter is not present, and FETCH waits indefinitely for the granted requester.

Test Plan:
- Reset, then req_vld=2'b01 with req_data byte 8'h41 and last=1 -> grant_id=0, req_rdy=2'b01 one cycle later, tx_din=8'h41, tx_din_vld held until the tx_din_rdy pulse, then IDLE with busy=0.
- Both requesters present 3-byte packets: req0 "ABC", req1 "xyz" -> tx_din sequence is 41,42,43,78,79,7A, with no interleaving; grant_id goes 0 then 1.
- req0 sends 2 one-byte packets while req1 is continuously valid -> order is req0, req1, req0; rotation is fair.
- NUM_REQ=3, only req2 valid, with the pointer at 2 after reset -> grant wraps to 2; after its packet and re-request, grant_id=2 again.
- Assert rstz=0 in SEND mid-packet, asynchronously between clock edges -> tx_din_vld=0 and busy=0 immediately; after release, req0 has top priority.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: req1 sends 1 non-last byte, then drops req_vld -> after 16 FETCH cycles, return to IDLE and the pending req0 is granted. Without the macro, the grant stays with req1.
